// File: rtl/tangnano20kdock.sv
// tangnano20kdock: 8N1 UART echo dock with boot banner and status LEDs.
// Full duplex on sys_clk; a 1-byte holding register sits between RX and TX.
module tangnano20kdock #(
  parameter int CLK_HZ = 4000000,
  parameter int BAUD   = 9600
) (
  input  logic       sys_clk,
  input  logic       btn1,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic [5:0] led_n
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [15:0] BIT_END  = 16'(DIV - 1);
  localparam logic [15:0] HALF_END = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

  logic rst_meta, rst_n;
  always_ff @(posedge sys_clk or negedge btn1)
    if (!btn1) {rst_meta, rst_n} <= 2'b00;
    else       {rst_meta, rst_n} <= {1'b1, rst_meta};

  logic [1:0]  us_cnt;
  logic [17:0] hb_cnt;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      us_cnt <= '0;
      hb_cnt <= '0;
    end else begin
      us_cnt <= us_cnt + 2'd1;
      if (us_cnt == 2'd3) hb_cnt <= hb_cnt + 18'd1;
    end

  logic rx_s1, rx_s2, rx_q;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else        {rx_s1, rx_s2, rx_q} <= {ser_rx, rx_s1, rx_s2};

  uart_st_t    rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_done, rx_ferr;

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      rx_st  <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 16'd1;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_done  = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rx_st)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_q && !rx_s2) rx_st_n = START;
      end
      START: if (rx_cnt == HALF_END) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n  = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_st_n = STOP;
      end
      STOP: if (rx_cnt == BIT_END) begin
        rx_st_n = IDLE;
        rx_done = rx_s2;
        rx_ferr = !rx_s2;
      end
      default: rx_st_n = IDLE;
    endcase
  end

  function automatic logic [7:0] banner(input logic [2:0] i);
    case (i)
      3'd0:    banner = 8'h53;
      3'd1:    banner = 8'h43;
      3'd2:    banner = 8'h4D;
      3'd3:    banner = 8'h50;
      3'd4:    banner = 8'h0D;
      default: banner = 8'h0A;
    endcase
  endfunction

  uart_st_t    tx_st, tx_st_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  ban_idx, ban_idx_n;
  logic        boot, boot_n;
  logic        hold_full, hold_take, have_ban, have_byte, load;
  logic [7:0]  hold_data;

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      tx_st   <= IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      ban_idx <= '0;
      boot    <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_bit  <= tx_bit_n;
      tx_sh   <= tx_sh_n;
      ban_idx <= ban_idx_n;
      boot    <= boot_n;
    end

  assign have_ban  = ban_idx < 3'd6;
  assign have_byte = have_ban || hold_full;

  // STOP chains straight into START so frames run back-to-back
  always_comb begin
    tx_st_n   = tx_st;
    tx_cnt_n  = tx_cnt + 16'd1;
    tx_bit_n  = tx_bit;
    tx_sh_n   = tx_sh;
    ban_idx_n = ban_idx;
    boot_n    = boot;
    load      = 1'b0;
    hold_take = 1'b0;
    unique case (tx_st)
      IDLE: if (boot) begin
        if (tx_cnt == BIT_END) begin
          boot_n = 1'b0;
          load   = have_byte;
        end
      end else begin
        tx_cnt_n = '0;
        load     = have_byte;
      end
      START: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_st_n  = DATA;
      end
      DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        tx_sh_n  = {1'b1, tx_sh[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_st_n = STOP;
      end
      STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        tx_st_n  = IDLE;
        load     = have_byte;
      end
      default: tx_st_n = IDLE;
    endcase
    if (load) begin
      tx_st_n  = START;
      tx_cnt_n = '0;
      tx_sh_n  = have_ban ? banner(ban_idx) : hold_data;
      if (have_ban) ban_idx_n = ban_idx + 3'd1;
      else          hold_take = 1'b1;
    end
  end

  assign ser_tx = (tx_st == START) ? 1'b0 :
                  (tx_st == DATA)  ? tx_sh[0] : 1'b1;

  logic ferr, ovr, tog;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      ferr      <= 1'b0;
      ovr       <= 1'b0;
      tog       <= 1'b0;
    end else begin
      if (rx_ferr) ferr <= 1'b1;
      if (rx_done) begin
        if (hold_full && !hold_take) begin
          ovr <= 1'b1;
        end else begin
          hold_full <= 1'b1;
          hold_data <= rx_sh;
          tog       <= ~tog;
        end
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end
    end

  assign led_n = {~tog, ~ovr, ~ferr, rx_st == IDLE, tx_st == IDLE, ~hb_cnt[17]};
endmodule

// File: tb/tb_tangnano20kdock.sv
// Bench for tangnano20kdock: table rows, random echo traffic and reset cases.
// A line decoder on ser_tx feeds a byte queue compared against a scoreboard.
module tb_tangnano20kdock;
  localparam int DIV = 417;
  localparam int FRAME = 10 * DIV;

  logic       sys_clk, btn1, ser_rx, ser_tx;
  logic [5:0] led_n;

  tangnano20kdock dut (
    .sys_clk(sys_clk),
    .btn1(btn1),
    .ser_rx(ser_rx),
    .ser_tx(ser_tx),
    .led_n(led_n)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [2:0] led53;
  } vec_t;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int rel;
  logic [7:0] mq[$];
  int         mt[$];
  logic [7:0] exp_q[$];
  logic [7:0] ban [6] = '{8'h53, 8'h43, 8'h4D, 8'h50, 8'h0D, 8'h0A};

  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever @(posedge sys_clk) cyc++;

  initial begin
    #2500000;
    $display("FAIL watchdog: time limit reached, miscompares so far %0d", miss);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : line_decoder
    bit busy;
    int cnt, st, k;
    logic [7:0] sh;
    busy = 0;
    cnt = 0;
    st = 0;
    sh = '0;
    forever begin
      @(negedge sys_clk);
      if (!btn1) begin
        busy = 0;
      end else if (!busy) begin
        if (ser_tx === 1'b0) begin
          busy = 1;
          cnt = 0;
          st = cyc;
        end
      end else begin
        cnt++;
        if (cnt == DIV / 2 && ser_tx !== 1'b0) begin
          busy = 0;
        end else if (cnt > DIV / 2 && (cnt - DIV / 2) % DIV == 0) begin
          k = (cnt - DIV / 2) / DIV;
          if (k <= 8) begin
            sh = {ser_tx, sh[7:1]};
          end else begin
            check("tx_stop_bit", ser_tx, 1);
            mq.push_back(sh);
            mt.push_back(st);
            busy = 0;
          end
        end
      end
    end
  end

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int k = 0;
    while (mq.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(nm, mq.size(), n);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    ser_rx = 0;
    repeat (DIV) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      repeat (DIV) @(negedge sys_clk);
    end
    ser_rx = stop;
    repeat (DIV) @(negedge sys_clk);
    ser_rx = 1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_banner(input string nm);
    int d0;
    d0 = mt[0] - rel;
    check({nm, "_first_start"}, (d0 >= DIV && d0 <= DIV + 2), 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_byte%0d", nm, i), mq[i], ban[i]);
      if (i > 0) check($sformatf("%s_gap%0d", nm, i), mt[i] - mt[i-1], FRAME);
    end
  endtask

  initial begin
    vec_t tbl[3];
    logic led5_e, ferr_e;
    logic [7:0] d;
    logic s;

    tbl[0] = '{d: 8'hA5, stop: 1'b1, led53: 3'b011};
    tbl[1] = '{d: 8'hFF, stop: 1'b1, led53: 3'b111};
    tbl[2] = '{d: 8'h31, stop: 1'b0, led53: 3'b110};

    btn1 = 0;
    ser_rx = 1;
    repeat (10) @(negedge sys_clk);
    check("rst_tx", ser_tx, 1);
    check("rst_led", led_n, 6'h3F);
    btn1 = 1;
    rel = cyc;

    wait_bytes(2, 12000, "b1_two_bytes");
    check("b1_first_start", (mt[0] - rel >= DIV && mt[0] - rel <= DIV + 2), 1);
    check("b1_byte0", mq[0], 8'h53);
    check("b1_byte1", mq[1], 8'h43);
    check("b1_gap1", mt[1] - mt[0], FRAME);
    repeat (1500) @(negedge sys_clk);
    check("b1_tx_busy_led", led_n[1], 0);
    btn1 = 0;
    #1;
    check("midframe_rst_tx", ser_tx, 1);
    check("midframe_rst_led", led_n, 6'h3F);
    repeat (10) @(negedge sys_clk);
    mq.delete();
    mt.delete();
    btn1 = 1;
    rel = cyc;

    wait_bytes(6, 27000, "b2_six_bytes");
    check_banner("b2");
    repeat (DIV) @(negedge sys_clk);
    check("b2_idle_leds", led_n[5:1], 5'h1F);
    mq.delete();
    mt.delete();

    ser_rx = 0;
    repeat (50) @(negedge sys_clk);
    check("glitch_rx_busy", led_n[2], 0);
    repeat (50) @(negedge sys_clk);
    ser_rx = 1;
    repeat (300) @(negedge sys_clk);
    check("glitch_leds", led_n[5:1], 5'h1F);
    check("glitch_no_echo", mq.size(), 0);

    led5_e = 1;
    ferr_e = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(tbl[i].d, tbl[i].stop);
      if (tbl[i].stop) begin
        exp_q.push_back(tbl[i].d);
        led5_e = ~led5_e;
      end else begin
        ferr_e = 1;
      end
      check($sformatf("row%0d_led53", i), led_n[5:3], tbl[i].led53);
    end

    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_byte(d, s);
      if (s) begin
        exp_q.push_back(d);
        led5_e = ~led5_e;
      end else begin
        ferr_e = 1;
      end
      check($sformatf("rand%0d_led53", i), led_n[5:3], {led5_e, 1'b1, ~ferr_e});
    end

    wait_bytes(exp_q.size(), 6000, "echo_count");
    foreach (exp_q[i]) check($sformatf("echo%0d", i), mq[i], exp_q[i]);

    btn1 = 0;
    repeat (10) @(negedge sys_clk);
    check("rst2_led", led_n, 6'h3F);
    mq.delete();
    mt.delete();
    btn1 = 1;
    rel = cyc;
    repeat (1000) @(negedge sys_clk);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    check("ovr_led4", led_n[4], 0);
    check("ovr_led5", led_n[5], 0);
    check("ovr_led3", led_n[3], 1);
    wait_bytes(7, 20000, "b3_seven_bytes");
    check_banner("b3");
    check("held_echo", mq[6], 8'h41);
    check("held_echo_gap", mt[6] - mt[5], FRAME);
    repeat (DIV) @(negedge sys_clk);
    check("dropped_tx_idle", led_n[1], 1);
    check("dropped_count", mq.size(), 7);
    check("heartbeat_low_half", led_n[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
